fp_int_to_half: RTL and testbench
=================================

FP_INT_TO_HALF -- requirements
Module: fp_int_to_half

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, giving the signed integer input width; legal range 12..64.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  upstream data valid.
REQ-005 SHALL have port ready_o  output  1  block accepts data_i this cycle.
REQ-006 SHALL have port data_i  input  IN_WIDTH  two's-complement integer, for example an accumulator sum.
REQ-007 SHALL have port valid_o  output  1  result valid.
REQ-008 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-009 SHALL have port result_o  output  16  IEEE-754 binary16 value.
REQ-010 SHALL have port inexact_o  output  1  rounding discarded nonzero bits.
REQ-011 SHALL have port overflow_o  output  1  magnitude exceeds the largest finite half value after rounding.

Function
REQ-012 SHALL be a two-stage pipeline: S1 registers sign, magnitude and zero flag; S2 registers the normalised, rounded result and flags.
REQ-013 SHALL have a latency of exactly 2 cycles from the accepting handshake (valid_i and ready_o) to valid_o when ready_i is held high.
REQ-014 SHALL sustain a throughput of one result per cycle when ready_i is held high.
REQ-015 SHALL advance each stage when that stage is empty or its content moves on in the same cycle; ready_o = ~s1_valid | s1_advance; no combinational path from ready_i to data registers beyond this chain.
REQ-016 SHALL hold result_o, inexact_o and overflow_o stable while valid_o=1 and ready_i=0.
REQ-017 SHALL hold any accepted item until it is consumed; no item is lost or duplicated, and order is preserved.
REQ-018 SHALL compute magnitude = |data_i| as an IN_WIDTH-bit unsigned value, so that -2^(IN_WIDTH-1) is representable exactly.
REQ-019 SHALL locate the leading one of the magnitude as lz, the index counted from the MSB, using fp_leading_one.
REQ-020 SHALL set unbiased exponent e = IN_WIDTH-1-lz and biased exponent = e+15.
REQ-021 SHALL left-shift the magnitude by lz, take mantissa = the 10 bits below the hidden one, guard = the next bit, sticky = OR of all remaining bits.
REQ-022 SHALL round to nearest, ties to even: increment when guard & (sticky | mantissa[0]); on mantissa carry-out, mantissa=0 and exponent+1.
REQ-023 SHALL set inexact_o = guard | sticky.
REQ-024 SHALL, when the biased exponent after rounding exceeds 30, output sign|0x7C00 (infinity) with overflow_o=1 and inexact_o=1.
REQ-025 SHALL, for zero input, output 0x0000 (never negative zero) with both flags at 0.
REQ-026 SHALL never produce subnormals or NaN.

Reset
REQ-027 SHALL, while rst_i is asserted, clear all valid bits asynchronously and force valid_o=0, result_o=0, inexact_o=0 and overflow_o=0.
REQ-028 SHALL drive ready_o=1 during and after reset.
REQ-029 SHALL discard any in-flight items when reset is asserted mid-operation; the first handshake after deassertion behaves as from idle.

Configuration
REQ-030 SHALL, when FP_INT_TO_HALF_SAT_EN is defined, replace infinity on overflow with sign|0x7BFF (max finite, 65504) while still asserting overflow_o and inexact_o.
REQ-031 SHALL, when FP_INT_TO_HALF_SAT_EN is undefined, behave per REQ-024.

Structure
REQ-032 SHALL take binary16 constants from shared package fp_pkg: EXP_BITS=5, MAN_BITS=10, EXP_BIAS=15, EXP_MAX_FINITE=30, FP16_INF=0x7C00, FP16_MAX=0x7BFF, plus a half_t typedef.
REQ-033 SHALL instantiate exactly one sub-module, fp_leading_one with LEN=IN_WIDTH, placed between the S1 and S2 registers.

Verification
REQ-034 SHALL cover: data_i=1 -> 0x3C00; data_i=-1 -> 0xBC00; data_i=0 -> 0x0000; flags 0; each valid_o exactly 2 cycles after acceptance.
REQ-035 SHALL cover rounding: 2049 -> 0x6800 inexact=1 (tie to even); 2051 -> 0x6802 inexact=1; 2050 -> 0x6801 inexact=0.
REQ-036 SHALL cover overflow: 65520 -> 0x7C00 overflow=1; -2147483648 -> 0xFC00 overflow=1; with FP_INT_TO_HALF_SAT_EN these give 0x7BFF and 0xFBFF.
REQ-037 SHALL cover back-pressure: stream 1..8 with ready_i low for cycles 3-5 -> ready_o drops once both stages are full, all 8 results arrive in order, and outputs stay stable while stalled.
REQ-038 SHALL cover reset mid-stream: rst_i pulsed with 2 items in flight -> valid_o=0 immediately, no stale result afterwards, and the next input 4 -> 0x4400.
REQ-039 SHALL cover random signed inputs against a reference model -> bit-exact result_o and flags.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary16 constants and the packed half-precision layout.
package fp_pkg;

   localparam int EXP_BITS       = 5;
   localparam int MAN_BITS       = 10;
   localparam int EXP_BIAS       = 15;
   localparam int EXP_MAX_FINITE = 30;

   localparam logic [15:0] FP16_INF = 16'h7C00;
   localparam logic [15:0] FP16_MAX = 16'h7BFF;

   typedef struct packed {
      logic                sign;
      logic [EXP_BITS-1:0] exp;
      logic [MAN_BITS-1:0] man;
   } half_t;

endpackage

// File: rtl/fp_leading_one.sv
// Leading-one locator: lz_o is the position of the highest set bit, counted down from the MSB.
module fp_leading_one #(
   parameter int LEN = 32,
   parameter int LZW = $clog2(LEN)
) (
   input  logic [LEN-1:0] vec_i,
   output logic [LZW-1:0] lz_o
);

   // Ascending scan: the highest set bit is written last and wins; all-zero input yields 0.
   always_comb begin
      lz_o = '0;
      for (int i = 0; i < LEN; i++) begin
         if (vec_i[i]) begin
            lz_o = LZW'(LEN - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_int_to_half.sv
// Signed integer to IEEE binary16, round-to-nearest-even; FP_INT_TO_HALF_SAT_EN saturates overflow to max finite.
// Latency 2 cycles (S1 sign/magnitude, S2 normalise/round), one result per cycle.
// Backpressure: each stage advances when empty or draining; ready_o = ~s1_valid | s1_advance.
module fp_int_to_half
   import fp_pkg::*;
#(
   parameter int IN_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [IN_WIDTH-1:0] data_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [15:0]         result_o,
   output logic                inexact_o,
   output logic                overflow_o
);

   localparam int LZW   = $clog2(IN_WIDTH);
   localparam int EXT_W = IN_WIDTH + MAN_BITS + 2;

`ifdef FP_INT_TO_HALF_SAT_EN
   localparam half_t OVF_VAL = half_t'(FP16_MAX);
`else
   localparam half_t OVF_VAL = half_t'(FP16_INF);
`endif

   logic                s1_valid_q, s1_valid_d;
   logic                s1_sign_q,  s1_sign_d;
   logic                s1_zero_q,  s1_zero_d;
   logic [IN_WIDTH-1:0] s1_mag_q,   s1_mag_d;

   logic                s2_valid_q, s2_valid_d;
   half_t               s2_res_q,   s2_res_d;
   logic                s2_inx_q,   s2_inx_d;
   logic                s2_ovf_q,   s2_ovf_d;

   logic                s1_advance;
   logic                s2_ready;
   logic [LZW-1:0]      lz;

   logic [EXT_W-1:0]    frac;
   logic [MAN_BITS-1:0] mant;
   logic                guard;
   logic                sticky;
   logic                round_inc;
   logic [MAN_BITS:0]   man_r;
   logic [7:0]          exp_b;
   logic [7:0]          exp_r;
   logic                ovf;
   half_t               res;
   logic                inx;

   fp_leading_one #(
      .LEN (IN_WIDTH)
   ) u_lead (
      .vec_i (s1_mag_q),
      .lz_o  (lz)
   );

   // Shifting one past lz drops the hidden one, leaving mantissa, guard and sticky bits at the top.
   always_comb begin
      frac      = {s1_mag_q, {(MAN_BITS + 2){1'b0}}} << lz << 1;
      mant      = frac[EXT_W-1 -: MAN_BITS];
      guard     = frac[EXT_W-1-MAN_BITS];
      sticky    = |frac[EXT_W-2-MAN_BITS:0];
      round_inc = guard & (sticky | mant[0]);
      man_r     = {1'b0, mant} + {{MAN_BITS{1'b0}}, round_inc};
      exp_b     = 8'(IN_WIDTH - 1 + EXP_BIAS) - 8'(lz);
      exp_r     = exp_b + {7'b0, man_r[MAN_BITS]};
      ovf       = exp_r > 8'(EXP_MAX_FINITE);
      inx       = guard | sticky;
      res       = '{sign: s1_sign_q, exp: exp_r[EXP_BITS-1:0], man: man_r[MAN_BITS-1:0]};
      if (s1_zero_q) begin
         res = '0;
         inx = 1'b0;
         ovf = 1'b0;
      end else if (ovf) begin
         res      = OVF_VAL;
         res.sign = s1_sign_q;
         inx      = 1'b1;
      end
   end

   always_comb begin
      s2_ready   = ~s2_valid_q | ready_i;
      s1_advance = s1_valid_q & s2_ready;
      ready_o    = ~s1_valid_q | s1_advance;

      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_mag_d   = s1_mag_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_inx_d   = s2_inx_q;
      s2_ovf_d   = s2_ovf_q;

      if (ready_o) begin
         s1_valid_d = valid_i;
         if (valid_i) begin
            s1_sign_d = data_i[IN_WIDTH-1];
            s1_zero_d = (data_i == '0);
            // Negating the most negative value wraps to 2^(W-1), which is its exact unsigned magnitude.
            s1_mag_d  = data_i[IN_WIDTH-1] ? -data_i : data_i;
         end
      end

      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d = res;
            s2_inx_d = inx;
            s2_ovf_d = ovf;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_mag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_inx_q   <= 1'b0;
         s2_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_zero_q  <= s1_zero_d;
         s1_mag_q   <= s1_mag_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_inx_q   <= s2_inx_d;
         s2_ovf_q   <= s2_ovf_d;
      end
   end

   assign valid_o    = s2_valid_q;
   assign result_o   = s2_res_q;
   assign inexact_o  = s2_inx_q;
   assign overflow_o = s2_ovf_q;

endmodule

// File: tb/tb_fp_int_to_half.sv
// Bench for fp_int_to_half: directed vector table, back-pressure, reset mid-stream and random streams.
module tb_fp_int_to_half;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic        valid_o;
   logic        ready_i;
   logic [15:0] result_o;
   logic        inexact_o;
   logic        overflow_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   fp_int_to_half #(.IN_WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_i     (data_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .inexact_o  (inexact_o),
      .overflow_o (overflow_o)
   );

`ifdef FP_INT_TO_HALF_SAT_EN
   localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
   localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

   typedef struct {
      logic [31:0] din;
      logic [15:0] res;
      logic        inx;
      logic        ovf;
   } vec_t;

   vec_t vecs[16];

   logic [17:0] exp_q[$];
   logic [17:0] item;
   logic        sb_en = 1'b0;
   int          rcv_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_val = '0;
   logic        saw_rdy_low = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: arithmetic quotient/remainder rounding on a 64-bit magnitude; returns {inx, ovf, result}.
   function automatic logic [17:0] model(input logic [31:0] d);
      logic [63:0] mag, q, rem, half;
      logic        sgn, inx;
      int          e, sh;
      sgn = d[31];
      mag = sgn ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
      if (mag == 0) return 18'h0;
      e = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) e = i;
      if (e <= 10) begin
         q   = mag << (10 - e);
         inx = 1'b0;
      end else begin
         sh   = e - 10;
         q    = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == 64'd2048) begin
            q = 64'd1024;
            e = e + 1;
         end
         inx = (rem != 0);
      end
      if (e > 15) return {1'b1, 1'b1, sgn, OVF_MAG};
      return {inx, 1'b0, sgn, 5'(e + 15), q[9:0]};
   endfunction

   function automatic logic [31:0] next_data(input int mode, input int idx);
      logic [31:0] r;
      if (mode == 1) return 32'(idx + 1);
      case ($urandom_range(0, 11))
         0:       r = 32'h0;
         1:       r = 32'h8000_0000;
         2:       r = 32'd65520;
         3:       r = 32'd2049;
         default: begin
            r = $urandom;
            r = r >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
         end
      endcase
      return r;
   endfunction

   // Scoreboard and stall-stability monitor, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (sb_en && !rst_i) begin
            if (stall_prev)
               check("stall_hold", {13'b0, valid_o, inexact_o, overflow_o, result_o}, stall_val);
            if (valid_o && ready_i) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 32'(result_o), 32'hFFFF_FFFF);
               end else begin
                  item = exp_q.pop_front();
                  check("stream_res", 32'(result_o), 32'(item[15:0]));
                  check("stream_flags", {30'b0, inexact_o, overflow_o}, {30'b0, item[17:16]});
                  rcv_cnt++;
               end
            end
            if (valid_i && ready_o) exp_q.push_back(model(data_i));
            stall_prev = valid_o && !ready_i;
            stall_val  = {13'b0, valid_o, inexact_o, overflow_o, result_o};
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   task automatic do_one(input vec_t v, input string nm);
      valid_i = 1'b1;
      data_i  = v.din;
      ready_i = 1'b1;
      @(negedge clk_i);
      check({nm, "_ready"}, 32'(ready_o), 32'd1);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      data_i  = '0;
      check({nm, "_lat1"}, 32'(valid_o), 32'd0);
      @(posedge clk_i); #1;
      check({nm, "_lat2"}, 32'(valid_o), 32'd1);
      check({nm, "_res"}, 32'(result_o), 32'(v.res));
      check({nm, "_inx"}, 32'(inexact_o), 32'(v.inx));
      check({nm, "_ovf"}, 32'(overflow_o), 32'(v.ovf));
      @(posedge clk_i); #1;
      check({nm, "_once"}, 32'(valid_o), 32'd0);
   endtask

   task automatic run_stream(input int n, input int mode, input string nm);
      int          idx = 0;
      int          cyc = 0;
      logic        hs;
      logic [31:0] cur;
      exp_q.delete();
      rcv_cnt     = 0;
      saw_rdy_low = 1'b0;
      cur         = next_data(mode, 0);
      sb_en       = 1'b1;
      while (idx < n && cyc < 3000) begin
         case (mode)
            1:       ready_i = !(cyc >= 3 && cyc <= 5);
            2:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b1;
         endcase
         valid_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         data_i  = cur;
         @(negedge clk_i);
         hs = valid_i & ready_o;
         if (!ready_o) saw_rdy_low = 1'b1;
         @(posedge clk_i); #1;
         if (hs) begin
            idx++;
            cur = next_data(mode, idx);
         end
         cyc++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int k = 0; k < 50 && rcv_cnt < n; k++) begin
         @(posedge clk_i); #1;
      end
      check({nm, "_count"}, 32'(rcv_cnt), 32'(n));
      check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
      if (mode == 0) check({nm, "_throughput"}, 32'(cyc), 32'(n));
      if (mode == 1) check({nm, "_ready_drop"}, 32'(saw_rdy_low), 32'd1);
      sb_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      vecs[0]  = '{32'd1,          16'h3C00, 1'b0, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFF,  16'hBC00, 1'b0, 1'b0};
      vecs[2]  = '{32'd0,          16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{32'd2049,       16'h6800, 1'b1, 1'b0};
      vecs[4]  = '{32'd2051,       16'h6802, 1'b1, 1'b0};
      vecs[5]  = '{32'd2050,       16'h6801, 1'b0, 1'b0};
      vecs[6]  = '{32'd65520,      {1'b0, OVF_MAG}, 1'b1, 1'b1};
      vecs[7]  = '{32'h8000_0000,  {1'b1, OVF_MAG}, 1'b1, 1'b1};
      vecs[8]  = '{32'd65504,      16'h7BFF, 1'b0, 1'b0};
      vecs[9]  = '{32'd65519,      16'h7BFF, 1'b1, 1'b0};
      vecs[10] = '{32'd4,          16'h4400, 1'b0, 1'b0};
      vecs[11] = '{32'hFFFF_FFFD,  16'hC200, 1'b0, 1'b0};
      vecs[12] = '{32'd4097,       16'h6C00, 1'b1, 1'b0};
      vecs[13] = '{32'h7FFF_FFFF,  {1'b0, OVF_MAG}, 1'b1, 1'b1};
      vecs[14] = '{32'd1024,       16'h6400, 1'b0, 1'b0};
      vecs[15] = '{32'd2,          16'h4000, 1'b0, 1'b0};

      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      #12;
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_ready_o", 32'(ready_o), 32'd1);
      check("rst_result", 32'(result_o), 32'd0);
      check("rst_flags", {30'b0, inexact_o, overflow_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("post_rst_ready", 32'(ready_o), 32'd1);

      for (int i = 0; i < 16; i++) do_one(vecs[i], $sformatf("vec%0d", i));

      run_stream(8, 1, "bp");
      run_stream(200, 0, "tput");
      run_stream(300, 2, "rand");

      // Two items in flight, then an asynchronous reset between clock edges.
      valid_i = 1'b1;
      ready_i = 1'b1;
      data_i  = 32'd100;
      @(posedge clk_i); #1;
      data_i  = 32'd200;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("inflight_valid", 32'(valid_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check("midrst_valid_o", 32'(valid_o), 32'd0);
      check("midrst_result", 32'(result_o), 32'd0);
      check("midrst_flags", {30'b0, inexact_o, overflow_o}, 32'd0);
      check("midrst_ready_o", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         if (valid_o) seen = 1'b1;
      end
      check("no_stale", 32'(seen), 32'd0);
      @(posedge clk_i); #1;
      do_one(vecs[10], "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
